// File: rtl/prog_load_if.sv
// Program-load bus: image word stream in, instruction-memory write port out.
// Macro: none.
// Ports (via modports):
//   in_valid/in_ready/in_data/in_last : valid/ready stream of image words
//   mem_we/mem_addr/mem_wdata         : instruction-memory write port
// master = the system side (stream source and memory); slave = the controller.
interface prog_load_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;
    logic            in_last;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_load_ctrl.sv
// Program-load controller: streams an instruction image into instruction memory
// at BASE_ADDR + n*STEP, holds the core in reset while loading and for HOLD_CYC
// cycles after the last write, then releases it. Supports reload from RUN/ERR.
// Optional macro PROG_LOAD_CSUM_EN: the in_last word is a checksum of the data
// words (not written); a mismatch raises csum_err and enters ERR.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse starting a load or reload
//   bus        : prog_load_if.slave (stream in, memory write out)
//   core_rst   : core reset, high except in RUN
//   busy       : LOAD or HOLD
//   done       : image loaded, core running
//   overflow   : sticky, image exceeded DEPTH words
//   count      : words written in the current load
//   csum_err   : checksum mismatch (only with PROG_LOAD_CSUM_EN)
module prog_load_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int unsigned     STEP      = 4,
    parameter int unsigned     HOLD_CYC  = 2,
    localparam int unsigned    CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    prog_load_if.slave    bus,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [CW-1:0] count
`ifdef PROG_LOAD_CSUM_EN
    ,
    output logic          csum_err
`endif
);

    localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            wr_fire;
    logic            ovf_set;
    logic            clr;
    logic [HW-1:0]   hold_q;
    logic [XLEN-1:0] wr_addr_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
`ifdef PROG_LOAD_CSUM_EN
    logic            csum_set;
    logic [XLEN-1:0] sum_q;
`endif

    // Ready is a pure state decode so the source sees it in the same cycle.
    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign accept        = bus.in_valid && (state_q == S_LOAD);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d  = state_q;
        wr_fire  = 1'b0;
        ovf_set  = 1'b0;
        clr      = 1'b0;
`ifdef PROG_LOAD_CSUM_EN
        csum_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    clr     = 1'b1;
                end
            end
            S_LOAD: begin
                if (accept) begin
`ifdef PROG_LOAD_CSUM_EN
                    // Last beat carries the checksum; only data words count
                    // against DEPTH.
                    if (bus.in_last) begin
                        if (sum_q == bus.in_data) begin
                            state_d = S_HOLD;
                        end else begin
                            state_d  = S_ERR;
                            csum_set = 1'b1;
                        end
                    end else if (count == CW'(DEPTH)) begin
                        state_d = S_ERR;
                        ovf_set = 1'b1;
                    end else begin
                        wr_fire = 1'b1;
                    end
`else
                    // Overflow wins over in_last: word DEPTH+1 is never written.
                    if (count == CW'(DEPTH)) begin
                        state_d = S_ERR;
                        ovf_set = 1'b1;
                    end else begin
                        wr_fire = 1'b1;
                        if (bus.in_last) begin
                            state_d = S_HOLD;
                        end
                    end
`endif
                end
            end
            S_HOLD: begin
                if (hold_q == HW'(HOLD_CYC - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    clr     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write port, counters and status flags; status decodes the next state so
    // every output is registered yet aligned with the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            wr_addr_q   <= BASE_ADDR;
            count       <= '0;
            hold_q      <= '0;
            overflow    <= 1'b0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_we_q <= wr_fire;
            if (wr_fire) begin
                mem_addr_q  <= wr_addr_q;
                mem_wdata_q <= bus.in_data;
                wr_addr_q   <= wr_addr_q + XLEN'(STEP);
                count       <= count + CW'(1);
            end
            if (clr) begin
                wr_addr_q <= BASE_ADDR;
                count     <= '0;
                overflow  <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            hold_q   <= ((state_q == S_HOLD) && (state_d == S_HOLD)) ? hold_q + HW'(1) : '0;
            core_rst <= (state_d != S_RUN);
            busy     <= (state_d == S_LOAD) || (state_d == S_HOLD);
            done     <= (state_d == S_RUN);
        end
    end

`ifdef PROG_LOAD_CSUM_EN
    // Running sum of written words and the sticky checksum error.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q    <= '0;
            csum_err <= 1'b0;
        end else begin
            if (wr_fire) begin
                sum_q <= sum_q + bus.in_data;
            end
            if (clr) begin
                sum_q    <= '0;
                csum_err <= 1'b0;
            end
            if (csum_set) begin
                csum_err <= 1'b1;
            end
        end
    end
`endif

endmodule
